// File: rtl/signal_generator_pkg.sv
// Shared definitions for the CCD phase signal generator: FSM encoding,
// register offsets within the Wishbone window and the PARALLEL slot count.
package signal_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARALLEL,
    ST_PIX_A,
    ST_PIX_B,
    ST_PIX_C,
    ST_PIX_D
  } sg_state_t;

  localparam logic [4:0] OFF_ENABLE    = 5'h00;
  localparam logic [4:0] OFF_FREQUENCY = 5'h04;
  localparam logic [4:0] OFF_PHI_P     = 5'h08;
  localparam logic [4:0] OFF_PHI_L1    = 5'h0C;
  localparam logic [4:0] OFF_PHI_L2    = 5'h10;
  localparam logic [4:0] OFF_PHI_R     = 5'h14;
  localparam logic [4:0] OFF_CLOCK     = 5'h18;
  localparam logic [4:0] OFF_RETURN    = 5'h1C;

  localparam int PARALLEL_SLOTS = 4;

endpackage

// File: rtl/signal_generator_tick_gen.sv
// Pixel-clock conditioning: 2-FF synchronizer, rising-edge tick and a slot
// divider that closes a slot every (fsel+1) ticks, fsel latched per slot.
module sg_tick_gen (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_src,
  input  logic [3:0] i_fsel,
  input  logic       i_clr,
  output logic       o_tick,
  output logic       o_slot_end
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [3:0] r_cnt;
  logic [3:0] r_len;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_tick     = r_sync2 & ~r_sync3;
  assign o_slot_end = o_tick & ~i_clr & (r_cnt == r_len);

  // While cleared the divider keeps reloading fsel, so the first slot after
  // leaving IDLE already uses the current divider setting.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_cnt <= 4'd0;
      r_len <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
      r_len <= i_fsel;
    end else if (o_tick) begin
      if (r_cnt == r_len) begin
        r_cnt <= 4'd0;
        r_len <= i_fsel;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/signal_generator.sv
// CCD phase generator with a Wishbone register window; register-controlled
// (i_test=1) or pin-controlled timing, registered phase outputs.
module signal_generator
  import signal_generator_pkg::*;
#(
  parameter logic [31:0] PASO_DEF          = 32'h5FA4,
  parameter logic [31:0] ENABLE_ADDRESS    = 32'h3000_0000,
  parameter logic [31:0] FREQUENCY_ADDRESS = 32'h3000_0004,
  parameter logic [31:0] PHI_P_ADDRESS     = 32'h3000_0008,
  parameter logic [31:0] PHI_L1_ADDRESS    = 32'h3000_000C,
  parameter logic [31:0] PHI_L2_ADDRESS    = 32'h3000_0010,
  parameter logic [31:0] PHI_R_ADDRESS     = 32'h3000_0014,
  parameter logic [31:0] CLOCK_ADDRESS     = 32'h3000_0018,
  parameter logic [31:0] RETURN_ADDRESS    = 32'h3000_001C
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic        i_test,
  output logic [4:0]  o_test,
  input  logic        i_enable,
  input  logic [3:0]  i_f_select,
  input  logic        i_clk,
  output logic        o_phi_p,
  output logic        o_phi_l1,
  output logic        o_phi_l2,
  output logic        o_phi_r
);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_en_reg;
  logic [3:0]  r_freq;
  logic        r_clk_reg;
  logic [4:0]  r_return;
  sg_state_t   r_state;
  logic [1:0]  r_pslot;
  logic [31:0] r_pix;
  logic        r_phi_p, r_phi_l1, r_phi_l2, r_phi_r;

  logic        w_req, w_hit, w_enable, w_src, w_clr, w_tick, w_slot_end;
  logic [4:0]  w_off;
  logic [3:0]  w_fsel;
  logic [31:0] w_rdata;
  sg_state_t   w_state_nxt;
  logic [1:0]  w_pslot_nxt;
  logic [31:0] w_pix_nxt;
  logic        w_phi_p, w_phi_l1, w_phi_l2, w_phi_r;
  logic        w_unused_data;

  assign w_unused_data = &{1'b0, i_wb_data[31:5]};

  assign w_enable = i_test ? r_en_reg  : i_enable;
  assign w_fsel   = i_test ? r_freq    : i_f_select;
  assign w_src    = i_test ? r_clk_reg : i_clk;
  assign w_clr    = ~w_enable | (r_state == ST_IDLE);

  sg_tick_gen u_tick_gen (
    .i_sys_clk  (i_wb_clk),
    .i_sys_rst  (i_wb_rst),
    .i_src      (w_src),
    .i_fsel     (w_fsel),
    .i_clr      (w_clr),
    .o_tick     (w_tick),
    .o_slot_end (w_slot_end)
  );

  assign w_req = i_wb_cyc & i_wb_stb & ~r_ack;

  always_comb begin
    w_hit = 1'b1;
    w_off = OFF_ENABLE;
    if      (i_wb_addr == ENABLE_ADDRESS)    w_off = OFF_ENABLE;
    else if (i_wb_addr == FREQUENCY_ADDRESS) w_off = OFF_FREQUENCY;
    else if (i_wb_addr == PHI_P_ADDRESS)     w_off = OFF_PHI_P;
    else if (i_wb_addr == PHI_L1_ADDRESS)    w_off = OFF_PHI_L1;
    else if (i_wb_addr == PHI_L2_ADDRESS)    w_off = OFF_PHI_L2;
    else if (i_wb_addr == PHI_R_ADDRESS)     w_off = OFF_PHI_R;
    else if (i_wb_addr == CLOCK_ADDRESS)     w_off = OFF_CLOCK;
    else if (i_wb_addr == RETURN_ADDRESS)    w_off = OFF_RETURN;
    else                                     w_hit = 1'b0;
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_off)
        OFF_ENABLE:    w_rdata[0]   = r_en_reg;
        OFF_FREQUENCY: w_rdata[3:0] = r_freq;
        OFF_PHI_P:     w_rdata[0]   = r_phi_p;
        OFF_PHI_L1:    w_rdata[0]   = r_phi_l1;
        OFF_PHI_L2:    w_rdata[0]   = r_phi_l2;
        OFF_PHI_R:     w_rdata[0]   = r_phi_r;
        OFF_CLOCK:     w_rdata[0]   = r_clk_reg;
        OFF_RETURN:    w_rdata[4:0] = r_return;
        default:       w_rdata      = 32'd0;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_ack     <= 1'b0;
      r_rdata   <= 32'd0;
      r_en_reg  <= 1'b0;
      r_freq    <= 4'd0;
      r_clk_reg <= 1'b0;
      r_return  <= 5'd0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_req ? w_rdata : 32'd0;
      if (w_req && i_wb_we && w_hit) begin
        case (w_off)
          OFF_ENABLE:    r_en_reg  <= i_wb_data[0];
          OFF_FREQUENCY: r_freq    <= i_wb_data[3:0];
          OFF_CLOCK:     r_clk_reg <= i_wb_data[0];
          OFF_RETURN:    r_return  <= i_wb_data[4:0];
          default:       ;
        endcase
      end
    end
  end

  // Disable has priority over any slot event, so it is checked first.
  always_comb begin
    w_state_nxt = r_state;
    w_pslot_nxt = r_pslot;
    w_pix_nxt   = r_pix;
    if (!w_enable) begin
      w_state_nxt = ST_IDLE;
      w_pslot_nxt = 2'd0;
      w_pix_nxt   = 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            w_state_nxt = ST_PARALLEL;
            w_pslot_nxt = 2'd0;
            w_pix_nxt   = 32'd0;
          end
        end
        ST_PARALLEL: begin
          w_pix_nxt = 32'd0;
          if (w_slot_end) begin
            if (r_pslot == 2'(PARALLEL_SLOTS - 1)) begin
              w_state_nxt = ST_PIX_A;
              w_pslot_nxt = 2'd0;
            end else begin
              w_pslot_nxt = r_pslot + 2'd1;
            end
          end
        end
        ST_PIX_A: if (w_slot_end) w_state_nxt = ST_PIX_B;
        ST_PIX_B: if (w_slot_end) w_state_nxt = ST_PIX_C;
        ST_PIX_C: if (w_slot_end) w_state_nxt = ST_PIX_D;
        ST_PIX_D: begin
          if (w_slot_end) begin
            if (r_pix < PASO_DEF - 32'd1) begin
              w_pix_nxt   = r_pix + 32'd1;
              w_state_nxt = ST_PIX_A;
            end else begin
              w_pix_nxt   = 32'd0;
              w_state_nxt = ST_PARALLEL;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_phi_p  = (w_state_nxt == ST_PARALLEL);
    w_phi_l1 = (w_state_nxt == ST_PIX_A) | (w_state_nxt == ST_PIX_B);
    w_phi_l2 = (w_state_nxt == ST_PIX_C) | (w_state_nxt == ST_PIX_D);
    w_phi_r  = (w_state_nxt == ST_PIX_A);
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_state  <= ST_IDLE;
      r_pslot  <= 2'd0;
      r_pix    <= 32'd0;
      r_phi_p  <= 1'b0;
      r_phi_l1 <= 1'b0;
      r_phi_l2 <= 1'b0;
      r_phi_r  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pslot  <= w_pslot_nxt;
      r_pix    <= w_pix_nxt;
      r_phi_p  <= w_phi_p;
      r_phi_l1 <= w_phi_l1;
      r_phi_l2 <= w_phi_l2;
      r_phi_r  <= w_phi_r;
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_data = r_rdata;
  assign o_phi_p   = r_phi_p;
  assign o_phi_l1  = r_phi_l1;
  assign o_phi_l2  = r_phi_l2;
  assign o_phi_r   = r_phi_r;
  assign o_test    = i_test ? r_return : {w_enable, r_phi_r, r_phi_l2, r_phi_l1, r_phi_p};

endmodule

// File: tb/tb_signal_generator.sv
// Bench for signal_generator: per-cycle comparison against a behavioural
// model (sequence position + tick counting) plus directed literal checks.
module tb_signal_generator;

  localparam logic [31:0] PASO   = 32'd3;
  localparam logic [31:0] A_EN   = 32'h3000_0000;
  localparam logic [31:0] A_FREQ = 32'h3000_0004;
  localparam logic [31:0] A_P    = 32'h3000_0008;
  localparam logic [31:0] A_L1   = 32'h3000_000C;
  localparam logic [31:0] A_L2   = 32'h3000_0010;
  localparam logic [31:0] A_R    = 32'h3000_0014;
  localparam logic [31:0] A_CLK  = 32'h3000_0018;
  localparam logic [31:0] A_RET  = 32'h3000_001C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [31:0] i_wb_addr = 32'd0, i_wb_data = 32'd0;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic        i_test = 1'b0;
  logic [4:0]  o_test;
  logic        i_enable = 1'b0;
  logic [3:0]  i_f_select = 4'd0;
  logic        i_clk_pin = 1'b0;
  logic        o_phi_p, o_phi_l1, o_phi_l2, o_phi_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  signal_generator #(.PASO_DEF(PASO)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .i_test(i_test), .o_test(o_test),
    .i_enable(i_enable), .i_f_select(i_f_select), .i_clk(i_clk_pin),
    .o_phi_p(o_phi_p), .o_phi_l1(o_phi_l1), .o_phi_l2(o_phi_l2), .o_phi_r(o_phi_r)
  );

  // Free-running pixel clock source on the pin (half period in system cycles)
  bit src_auto = 1'b0;
  int src_half = 2;
  int src_cnt  = 0;
  always @(negedge clk) begin
    if (src_auto) begin
      src_cnt++;
      if (src_cnt >= src_half) begin
        src_cnt   = 0;
        i_clk_pin = ~i_clk_pin;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_en_r = 1'b0, m_clk_r = 1'b0;
  logic [3:0]  m_freq = 4'd0;
  logic [4:0]  m_ret = 5'd0;
  logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  bit          m_active = 1'b0;
  int          m_pos = 0, m_tc = 0, m_len = 0;
  logic        m_p = 1'b0, m_l1 = 1'b0, m_l2 = 1'b0, m_r = 1'b0;
  logic        t_en, t_src, t_tick, t_req;
  logic [3:0]  t_fs;
  logic [31:0] t_rd;

  // Sequence position: 0..3 are PARALLEL slots, then 4 slots per pixel.
  function automatic logic [3:0] exp_phases(input bit act, input int pos);
    int k;
    if (!act) return 4'b0000;
    if (pos < 4) return 4'b0001;
    k = (pos - 4) % 4;
    case (k)
      0:       return 4'b1010;
      1:       return 4'b0010;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      A_EN:    return {31'd0, m_en_r};
      A_FREQ:  return {28'd0, m_freq};
      A_P:     return {31'd0, m_p};
      A_L1:    return {31'd0, m_l1};
      A_L2:    return {31'd0, m_l2};
      A_R:     return {31'd0, m_r};
      A_CLK:   return {31'd0, m_clk_r};
      A_RET:   return {27'd0, m_ret};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack = 1'b0; m_rdata = 32'd0; m_en_r = 1'b0; m_clk_r = 1'b0;
      m_freq = 4'd0; m_ret = 5'd0; h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      m_active = 1'b0; m_pos = 0; m_tc = 0; m_len = 0;
      {m_r, m_l2, m_l1, m_p} = 4'b0000;
    end else begin
      t_en  = i_test ? m_en_r  : i_enable;
      t_fs  = i_test ? m_freq  : i_f_select;
      t_src = i_test ? m_clk_r : i_clk_pin;
      // a rise of the source is seen as a tick three edges after it is sampled
      t_tick = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = t_src;
      t_req = i_wb_cyc & i_wb_stb & ~m_ack;
      t_rd  = model_read(i_wb_addr);
      if (t_req && i_wb_we) begin
        case (i_wb_addr)
          A_EN:    m_en_r  = i_wb_data[0];
          A_FREQ:  m_freq  = i_wb_data[3:0];
          A_CLK:   m_clk_r = i_wb_data[0];
          A_RET:   m_ret   = i_wb_data[4:0];
          default: ;
        endcase
      end
      m_rdata = t_req ? t_rd : 32'd0;
      m_ack   = t_req;
      if (!t_en) begin
        m_active = 1'b0; m_pos = 0; m_tc = 0;
      end else if (!m_active) begin
        if (t_tick) begin
          m_active = 1'b1; m_pos = 0; m_tc = 0; m_len = int'(t_fs);
        end
      end else if (t_tick) begin
        m_tc++;
        if (m_tc == m_len + 1) begin
          m_tc = 0;
          m_pos++;
          if (m_pos == 4 + 4 * int'(PASO)) m_pos = 0;
          m_len = int'(t_fs);
        end
      end
      {m_r, m_l2, m_l1, m_p} = exp_phases(m_active, m_pos);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [4:0] e_test;
  logic [3:0] g_ph;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      e_test = i_test ? m_ret : {(i_test ? m_en_r : i_enable), m_r, m_l2, m_l1, m_p};
      g_ph   = {o_phi_r, o_phi_l2, o_phi_l1, o_phi_p};
      n_tests++;
      if (g_ph !== {m_r, m_l2, m_l1, m_p} || o_wb_ack !== m_ack ||
          o_wb_data !== m_rdata || o_test !== e_test) begin
        n_fail++;
        $display("FAIL cycle t=%0t got ph=%b ack=%b data=%0h test=%b expected ph=%b ack=%b data=%0h test=%b",
                 $time, g_ph, o_wb_ack, o_wb_data, o_test,
                 {m_r, m_l2, m_l1, m_p}, m_ack, m_rdata, e_test);
      end
      n_tests++;
      if ((o_phi_l1 & o_phi_l2) | (o_phi_p & (o_phi_l1 | o_phi_l2 | o_phi_r))) begin
        n_fail++;
        $display("FAIL overlap t=%0t got ph=%b required exclusive phases", $time, g_ph);
      end
    end
  end

  int r_rises = 0;
  logic prev_r = 1'b0;
  always @(posedge clk) begin
    #2;
    if (o_phi_r && !prev_r) r_rises++;
    prev_r = o_phi_r;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic phase_bit(input int k);
    logic [3:0] v;
    v = {o_phi_r, o_phi_l2, o_phi_l1, o_phi_p};
    return v[k[1:0]];
  endfunction

  task automatic wait_level(input string name, input int k, input logic lvl,
                            input int budget, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (phase_bit(k) == lvl) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: phase %0d never reached %b within %0d cycles", name, k, lvl, budget);
    end
  endtask

  task automatic wait_ack(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (o_wb_ack) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got no ack required ack", name);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    wait_ack("wb_write_ack");
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    wait_ack("wb_read_ack");
    d = o_wb_data;
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  // CLOCK register toggled by back-to-back writes with cyc/stb held high
  task automatic clock_toggle(input int nwrites, input bit stop_on_l2);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = A_CLK;
    for (int i = 0; i < nwrites; i++) begin
      i_wb_data = (i % 2 == 0) ? 32'd1 : 32'd0;
      wait_ack("clock_toggle_ack");
      if (stop_on_l2 && o_phi_l2) break;
      @(negedge clk);
    end
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int c, plen, snap;
  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_phases", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'd0);
    chk("reset_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("reset_data", o_wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_test_bus", {27'd0, o_test}, 32'd0);
    chk("idle_phases", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'd0);

    // pin mode, fsel=0, one tick every 4 cycles
    src_auto = 1'b1; src_half = 2;
    @(negedge clk); i_enable = 1'b1;
    wait_level("p_rise1", 0, 1'b1, 200, c);
    wait_level("p_fall1", 0, 1'b0, 200, plen);
    chk("phi_p_len_fsel0", plen, 32'd16);
    snap = r_rises;
    wait_level("p_rise2", 0, 1'b1, 400, c);
    chk("pixels_per_line", r_rises - snap, 32'd3);
    chk("line_len_fsel0", c, 32'd48);

    // fsel=3: slots of 4 ticks; the change lands mid-slot
    @(negedge clk); i_f_select = 4'd3;
    wait_level("p_fall2", 0, 1'b0, 2000, c);
    wait_level("p_rise3", 0, 1'b1, 2000, c);
    wait_level("p_fall3", 0, 1'b0, 2000, plen);
    chk("phi_p_len_fsel3", plen, 32'd64);
    repeat (6) @(negedge clk);
    i_f_select = 4'd1;
    repeat (200) @(negedge clk);

    // reset mid-sequence aborts immediately, restarts at PARALLEL
    i_f_select = 4'd0;
    @(negedge clk); rst = 1'b1;
    #1 chk("reset_abort", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_level("restart_parallel", 0, 1'b1, 100, c);
    chk("restart_no_l1", {31'd0, o_phi_l1}, 32'd0);

    // register-controlled mode
    @(negedge clk);
    src_auto = 1'b0; i_enable = 1'b0; i_test = 1'b1;
    wb_write(A_FREQ, 32'd0);
    wb_write(A_EN, 32'd1);
    snap = r_rises;
    clock_toggle(40, 1'b0);
    repeat (10) @(negedge clk);
    chk("test_mode_pixels", r_rises - snap, 32'd3);
    chk("test_mode_back_to_p", {31'd0, o_phi_p}, 32'd1);

    // disable in PIX_C, then restart
    clock_toggle(80, 1'b1);
    chk("in_pix_c", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'h4);
    wb_write(A_EN, 32'd0);
    @(posedge clk); #1;
    chk("disable_clears", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'd0);
    wb_write(A_EN, 32'd1);
    clock_toggle(6, 1'b0);
    repeat (6) @(negedge clk);
    chk("reenable_parallel", {28'd0, o_phi_r, o_phi_l2, o_phi_l1, o_phi_p}, 32'd1);

    // register readback, RETURN bus, unmapped access
    wb_write(A_RET, 32'h1F);
    chk("o_test_return", {27'd0, o_test}, 32'h1F);
    wb_read(A_P, rd);   chk("read_phi_p", rd, 32'd1);
    wb_read(A_L1, rd);  chk("read_phi_l1", rd, 32'd0);
    wb_write(A_FREQ, 32'hFFFF_FFFA);
    wb_read(A_FREQ, rd); chk("read_freq", rd, 32'hA);
    wb_read(32'h3000_0040, rd); chk("read_unmapped", rd, 32'd0);
    wb_write(32'h3000_0040, 32'hFFFF_FFFF);
    wb_read(A_RET, rd); chk("read_return", rd, 32'h1F);

    // randomized traffic, checked every cycle against the model
    i_test = 1'b0; i_enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) i_clk_pin = ~i_clk_pin;
      if ($urandom_range(0, 99) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 39) == 0) i_f_select = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) i_test = ~i_test;
      i_wb_cyc  = ($urandom_range(0, 3) == 0);
      i_wb_stb  = i_wb_cyc;
      i_wb_we   = $urandom_range(0, 1) == 1;
      i_wb_addr = 32'h3000_0000 + 32'($urandom_range(0, 8) * 4);
      i_wb_data = $urandom;
      if (i == 2500) rst = 1'b1;
      if (i == 2503) rst = 1'b0;
    end
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
